// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and limits for the stopwatch datapath
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } sw_state_e;

    localparam int SEC_MAX = 59;
    // The minutes counter will take its limit from here once it moves over.
    localparam int MIN_MAX = 99;

    // Next value of a 0..SEC_MAX seconds counter after one counted second.
    function automatic logic [5:0] sec_next(input logic [5:0] s);
        return (s == 6'(SEC_MAX)) ? 6'd0 : s + 6'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clk-to-1Hz prescaler with run/hold/clear control
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    localparam int PRESC_W = $clog2(TICKS_PER_SEC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               hold,
    input  logic               clr,
    output logic [PRESC_W-1:0] count,
    output logic               tc
);

    localparam logic [PRESC_W-1:0] TC_VAL = PRESC_W'(TICKS_PER_SEC - 1);

    assign tc = (count == TC_VAL);

    // Count while running, freeze while held so a pause keeps the fractional second, else park at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= tc ? '0 : count + 1'b1;
        end else if (!hold) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/seconds_control.sv
// rtl/seconds_control.sv - stopwatch run/pause FSM, 1 Hz tick and 0..59 seconds counter (optional LAP_HOLD_EN display hold)
module seconds_control
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [1:0] state,
    output logic [5:0] seconds,
    output logic [5:0] seconds_disp,
    output logic       sec_tick,
    output logic       minute_en,
    output logic       minutes_clr
);

    localparam int PRESC_W = $clog2(TICKS_PER_SEC);

    sw_state_e          state_q;
    sw_state_e          state_d;
    logic [5:0]         seconds_q;
    logic [5:0]         seconds_d;
    logic [PRESC_W-1:0] unused_presc_count;
    logic               presc_tc;

    // Prescaler advances for the whole RUNNING cycle, including the one carrying stop,
    // so the second that ends on a stop edge is still counted.
    tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == ST_RUNNING),
        .hold  (state_q == ST_PAUSED),
        .clr   (clear),
        .count (unused_presc_count),
        .tc    (presc_tc)
    );

    assign sec_tick    = (state_q == ST_RUNNING) && presc_tc && !clear;
    assign minute_en   = sec_tick && (seconds_q == 6'(SEC_MAX));
    assign minutes_clr = clear && rst_n;
    assign state       = state_q;
    assign seconds     = seconds_q;

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats stop, stop beats start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start && !stop) state_d = ST_RUNNING;
                ST_RUNNING: if (stop)           state_d = ST_PAUSED;
                ST_PAUSED:  if (start && !stop) state_d = ST_RUNNING;
                default:                        state_d = ST_IDLE;
            endcase
        end
    end

    // Next seconds value: clear wins over a pending tick.
    always_comb begin
        seconds_d = seconds_q;
        if (clear) begin
            seconds_d = 6'd0;
        end else if (sec_tick) begin
            seconds_d = sec_next(seconds_q);
        end
    end

    // Seconds counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seconds_q <= 6'd0;
        end else begin
            seconds_q <= seconds_d;
        end
    end

`ifdef LAP_HOLD_EN
    logic hold_q;
    logic hold_d;
    logic lap_ok;

    assign lap_ok = lap && !clear && (state_q == ST_RUNNING || state_q == ST_PAUSED);

    // Hold flag toggles on lap; leaving the running/paused states always drops it.
    always_comb begin
        hold_d = hold_q;
        if (clear || state_d == ST_IDLE) begin
            hold_d = 1'b0;
        end else if (lap_ok) begin
            hold_d = !hold_q;
        end
    end

    // Display register: capture on entering hold, freeze while held, otherwise follow seconds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= 1'b0;
            seconds_disp <= 6'd0;
        end else begin
            hold_q <= hold_d;
            if (!hold_d) begin
                seconds_disp <= seconds_d;
            end else if (!hold_q) begin
                seconds_disp <= seconds_q;
            end
        end
    end
`else
    logic unused_lap;

    assign unused_lap   = lap;
    assign seconds_disp = seconds_q;
`endif

endmodule

// File: tb/tb_seconds_control.sv
// tb/tb_seconds_control.sv - scoreboard bench for seconds_control with TICKS_PER_SEC=4
module tb_seconds_control;

    localparam int T = 4;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] sec;
        logic [5:0] disp;
        logic       tick;
        logic       men;
        logic       mclr;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [1:0] state;
    logic [5:0] seconds;
    logic [5:0] seconds_disp;
    logic       sec_tick;
    logic       minute_en;
    logic       minutes_clr;

    int checks = 0;
    int errors = 0;

    snap_t exp_q[$];
    snap_t act_q[$];

    // reference model state
    logic [1:0] m_state;
    logic [1:0] m_presc;
    logic [5:0] m_sec;
    logic       m_hold;
    logic [5:0] m_disp;

    seconds_control #(.TICKS_PER_SEC(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .lap          (lap),
        .state        (state),
        .seconds      (seconds),
        .seconds_disp (seconds_disp),
        .sec_tick     (sec_tick),
        .minute_en    (minute_en),
        .minutes_clr  (minutes_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 2'd0;
        m_presc = 2'd0;
        m_sec   = 6'd0;
        m_hold  = 1'b0;
        m_disp  = 6'd0;
    endtask

    // One clock: drive at negedge, push expected/actual, advance the model on the posedge.
    task automatic step(input logic s, input logic p, input logic c, input logic l, output snap_t a);
        snap_t      e;
        logic       tick;
        logic [1:0] ns;
        logic [1:0] np;
        logic [5:0] nsec;
        logic       nh;
        @(negedge clk);
        start = s; stop = p; clear = c; lap = l;
        #1;
        tick   = (m_state == 2'd1) && (m_presc == 2'(T - 1)) && !c;
        e.st   = m_state;
        e.sec  = m_sec;
`ifdef LAP_HOLD_EN
        e.disp = m_hold ? m_disp : m_sec;
`else
        e.disp = m_sec;
`endif
        e.tick = tick;
        e.men  = tick && (m_sec == 6'd59);
        e.mclr = c;
        exp_q.push_back(e);
        a = '{state, seconds, seconds_disp, sec_tick, minute_en, minutes_clr};
        act_q.push_back(a);
        ns = m_state;
        if (c) ns = 2'd0;
        else if (m_state == 2'd0 && s && !p) ns = 2'd1;
        else if (m_state == 2'd1 && p) ns = 2'd2;
        else if (m_state == 2'd2 && s && !p) ns = 2'd1;
        np = m_presc;
        if (c || m_state == 2'd0) np = 2'd0;
        else if (m_state == 2'd1) np = (m_presc == 2'(T - 1)) ? 2'd0 : m_presc + 2'd1;
        nsec = m_sec;
        if (c) nsec = 6'd0;
        else if (tick) nsec = (m_sec == 6'd59) ? 6'd0 : m_sec + 6'd1;
        nh = m_hold;
        if (c || ns == 2'd0) nh = 1'b0;
        else if (l && m_state != 2'd0) nh = !m_hold;
        @(posedge clk);
        m_disp  = !nh ? nsec : (!m_hold ? m_sec : m_disp);
        m_hold  = nh;
        m_state = ns;
        m_presc = np;
        m_sec   = nsec;
    endtask

    // Idle-step until the model reaches RUNNING with the given seconds/prescaler values.
    task automatic run_until(input logic [5:0] ts, input logic [1:0] tp, output bit ok);
        snap_t a;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_state == 2'd1 && m_sec == ts && m_presc == tp) begin
                ok = 1'b1;
                break;
            end
            step(0, 0, 0, 0, a);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({state, seconds, seconds_disp, sec_tick, minute_en, minutes_clr} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: actual %h required 0",
                     {state, seconds, seconds_disp, sec_tick, minute_en, minutes_clr});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        snap_t a, e;
        step(1, 0, 0, 0, a);
        checks++;
        if (a.st !== 2'd0) begin errors++; $display("FAIL latency_pre_state: actual %0d required 0", a.st); end
        for (int k = 1; k <= 61; k++) begin
            step(0, 0, 0, 0, a);
            checks++;
            if (a.st !== 2'd1) begin errors++; $display("FAIL latency_state k=%0d: actual %0d required 1", k, a.st); end
            if (k <= 4) begin
                checks++;
                if (a.tick !== (k == 4)) begin
                    errors++;
                    $display("FAIL latency_tick k=%0d: actual %0d required %0d", k, a.tick, (k == 4));
                end
            end
            if (k == 5) begin
                checks++;
                if (a.sec !== 6'd1) begin errors++; $display("FAIL latency_sec1: actual %0d required 1", a.sec); end
            end
            if (k == 61) begin
                checks++;
                if (a.sec !== 6'd15) begin errors++; $display("FAIL latency_sec15: actual %0d required 15", a.sec); end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL latency_sb: actual %h required %h", a, e); end
        end
    endtask

    task automatic test_wrap();
        snap_t a, e;
        int men_cnt = 0;
        int wrap_at = -1;
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 0, a);
            if (a.men) begin
                men_cnt++;
                wrap_at = i;
                checks++;
                if (a.tick !== 1'b1 || a.sec !== 6'd59) begin
                    errors++;
                    $display("FAIL wrap_men_cycle: actual tick=%0d sec=%0d required tick=1 sec=59", a.tick, a.sec);
                end
            end
            if (wrap_at >= 0 && i == wrap_at + 1) begin
                checks++;
                if (a.sec !== 6'd0) begin errors++; $display("FAIL wrap_sec0: actual %0d required 0", a.sec); end
            end
            if (wrap_at >= 0 && i == wrap_at + 8) break;
        end
        checks++;
        if (men_cnt != 1) begin errors++; $display("FAIL wrap_men_count: actual %0d required 1", men_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL wrap_sb: actual %h required %h", a, e); end
        end
    endtask

    task automatic test_pause();
        snap_t a, e;
        bit ok;
        logic [5:0] held;
        run_until(6'd3, 2'd1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pause_reach: actual timeout required reached"); end
        step(0, 1, 0, 0, a);
        held = a.sec;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, a);
            checks++;
            if (a.st !== 2'd2 || a.tick !== 1'b0 || a.sec !== held) begin
                errors++;
                $display("FAIL pause_frozen i=%0d: actual st=%0d tick=%0d sec=%0d required st=2 tick=0 sec=%0d",
                         i, a.st, a.tick, a.sec, held);
            end
        end
        step(1, 0, 0, 0, a);
        step(0, 0, 0, 0, a);
        checks++;
        if (a.tick !== 1'b0) begin errors++; $display("FAIL resume_tick1: actual %0d required 0", a.tick); end
        step(0, 0, 0, 0, a);
        checks++;
        if (a.tick !== 1'b1) begin errors++; $display("FAIL resume_tick2: actual %0d required 1", a.tick); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL pause_sb: actual %h required %h", a, e); end
        end
    endtask

    task automatic test_priority();
        snap_t a, e;
        step(0, 0, 1, 0, a);
        step(1, 1, 0, 0, a);
        step(0, 0, 0, 0, a);
        checks++;
        if (a.st !== 2'd0) begin errors++; $display("FAIL idle_start_stop: actual %0d required 0", a.st); end
        step(1, 0, 0, 0, a);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, a);
        step(0, 1, 0, 0, a);
        step(0, 0, 0, 0, a);
        checks++;
        if (a.st !== 2'd2) begin errors++; $display("FAIL paused_state: actual %0d required 2", a.st); end
        step(1, 0, 1, 0, a);
        checks++;
        if (a.mclr !== 1'b1 || a.men !== 1'b0) begin
            errors++;
            $display("FAIL clear_start_pulse: actual mclr=%0d men=%0d required mclr=1 men=0", a.mclr, a.men);
        end
        step(0, 0, 0, 0, a);
        checks++;
        if (a.st !== 2'd0 || a.sec !== 6'd0 || a.mclr !== 1'b0) begin
            errors++;
            $display("FAIL clear_start_after: actual st=%0d sec=%0d mclr=%0d required 0 0 0", a.st, a.sec, a.mclr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL priority_sb: actual %h required %h", a, e); end
        end
    endtask

    task automatic test_clear_at_59();
        snap_t a, e;
        bit ok;
        step(1, 0, 0, 0, a);
        run_until(6'd59, 2'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clr59_reach: actual timeout required reached"); end
        step(0, 0, 1, 0, a);
        checks++;
        if (a.tick !== 1'b0 || a.men !== 1'b0 || a.mclr !== 1'b1 || a.sec !== 6'd59) begin
            errors++;
            $display("FAIL clr59_cycle: actual tick=%0d men=%0d mclr=%0d sec=%0d required 0 0 1 59",
                     a.tick, a.men, a.mclr, a.sec);
        end
        step(0, 0, 0, 0, a);
        checks++;
        if (a.sec !== 6'd0 || a.st !== 2'd0) begin
            errors++;
            $display("FAIL clr59_after: actual sec=%0d st=%0d required 0 0", a.sec, a.st);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL clr59_sb: actual %h required %h", a, e); end
        end
    endtask

    task automatic test_lap();
        snap_t a, e;
        bit ok;
        step(1, 0, 0, 0, a);
`ifdef LAP_HOLD_EN
        run_until(6'd7, 2'd0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lap_reach7: actual timeout required reached"); end
        step(0, 0, 0, 1, a);
        while (m_sec != 6'd12 || m_presc != 2'd0) begin
            step(0, 0, 0, 0, a);
            checks++;
            if (a.disp !== 6'd7) begin errors++; $display("FAIL lap_frozen: actual %0d required 7", a.disp); end
        end
        checks++;
        if (a.sec !== 6'd12 && a.sec !== 6'd11) begin
            errors++;
            $display("FAIL lap_underneath: actual %0d required 11 or 12", a.sec);
        end
        step(0, 0, 0, 1, a);
        step(0, 0, 0, 0, a);
        checks++;
        if (a.disp !== 6'd12) begin errors++; $display("FAIL lap_release: actual %0d required 12", a.disp); end
`else
        run_until(6'd2, 2'd0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lap_reach2: actual timeout required reached"); end
        step(0, 0, 0, 1, a);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, a);
            checks++;
            if (a.disp !== a.sec) begin
                errors++;
                $display("FAIL lap_ignored: actual disp=%0d required %0d", a.disp, a.sec);
            end
        end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL lap_sb: actual %h required %h", a, e); end
        end
    endtask

    task automatic test_async_reset();
        snap_t a, e;
        bit ok;
        run_until(m_sec, 2'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL areset_reach: actual timeout required reached"); end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        #1;
        checks++;
        if (sec_tick !== 1'b1 || seconds === 6'd0) begin
            errors++;
            $display("FAIL areset_pre: actual tick=%0d sec=%0d required tick=1 sec>0", sec_tick, seconds);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, seconds, seconds_disp, sec_tick, minute_en, minutes_clr} !== 17'd0) begin
            errors++;
            $display("FAIL areset_outputs: actual %h required 0",
                     {state, seconds, seconds_disp, sec_tick, minute_en, minutes_clr});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, a);
        checks++;
        if (a.st !== 2'd0 || a.sec !== 6'd0) begin
            errors++;
            $display("FAIL areset_after: actual st=%0d sec=%0d required 0 0", a.st, a.sec);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL areset_sb: actual %h required %h", a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_pause();
        test_priority();
        test_clear_at_59();
        test_lap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
